// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with IDLE/EXEC/DONE sequencing; optional shift-add MUL enabled by ALU_SEQ_MUL_EN
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             oe,
  output logic [WIDTH-1:0] aluout,
  output logic             carryout,
  output logic             overout,
  output logic             zeroout,
  output logic             negout,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2;
  localparam int CW = SHW + 1;
  logic [1:0] st_q, st_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] w_q, w_d, b_q, b_d, res_q, res_d;
  logic cin_q, cin_d, so_q, so_d, c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bb, sh_val, r, mul_lo;
  logic [WIDTH:0] sum;
  logic ci, ov, is_sh, shifting, sh_out, sh_v, c, v, fin, upd_res, upd_flg, mul_hi;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
  logic [2*WIDTH-1:0] prod_q, prod_nx;
  logic [WIDTH:0] macc;
  assign macc = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, w_q} : '0);
  assign prod_nx = {macc, prod_q[WIDTH-1:1]};
  assign mul_lo = prod_nx[WIDTH-1:0];
  assign mul_hi = |prod_nx[2*WIDTH-1:WIDTH];
  // partial product: loads b on accept, one add-and-shift step per EXEC cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prod_q <= '0;
    else if (st_q == S_IDLE && start) prod_q <= {{WIDTH{1'b0}}, b};
    else if (st_q == S_EXEC) prod_q <= prod_nx;
`else
  localparam bit MUL_EN = 1'b0;
  assign mul_lo = '0;
  assign mul_hi = 1'b0;
`endif
  assign is_sh = op_q inside {4'd8, 4'd9, 4'd10};
  assign bb = (op_q == 4'd2 || op_q == 4'd3 || op_q == 4'd11) ? ~b_q : b_q;
  assign ci = (op_q == 4'd1 || op_q == 4'd3) ? cin_q : (op_q == 4'd2 || op_q == 4'd11);
  assign sum = {1'b0, w_q} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
  assign ov = (w_q[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != w_q[WIDTH-1]);
  assign shifting = cnt_q != '0;
  assign sh_val = op_q == 4'd8 ? {w_q[WIDTH-2:0], 1'b0} : {op_q == 4'd10 && w_q[WIDTH-1], w_q[WIDTH-1:1]};
  assign sh_out = op_q == 4'd8 ? w_q[WIDTH-1] : w_q[0];
  assign sh_v = so_q || (shifting && op_q == 4'd8 && sh_val[WIDTH-1] != w_q[WIDTH-1]);
  assign fin = is_sh ? cnt_q <= CW'(1) : (MUL_EN && op_q == 4'd12) ? cnt_q == CW'(1) : 1'b1;
  assign upd_res = op_q < 4'd11 || (MUL_EN && op_q == 4'd12);
  assign upd_flg = op_q < 4'd12 || (MUL_EN && op_q == 4'd12);
  assign aluout = oe ? res_q : '0;
  assign {carryout, overout, zeroout, negout} = {c_q, v_q, z_q, n_q};
  assign busy = st_q != S_IDLE;
  assign done = st_q == S_DONE;
  // result and flags of the final EXEC cycle for the latched opcode
  always_comb begin
    r = w_q;
    c = 1'b0;
    v = 1'b0;
    case (op_q)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd11: begin r = sum[WIDTH-1:0]; c = sum[WIDTH]; v = ov; end
      4'd4: r = w_q & b_q;
      4'd5: r = w_q | b_q;
      4'd6: r = w_q ^ b_q;
      4'd7: r = ~w_q;
      4'd8, 4'd9, 4'd10: begin r = shifting ? sh_val : w_q; c = shifting && sh_out; v = sh_v; end
      4'd12: begin r = mul_lo; c = mul_hi; v = mul_hi; end
      default: ;
    endcase
  end
  // sequencing: latch operands on accept, step shifts/multiply in EXEC, commit on leaving EXEC
  always_comb begin
    {st_d, op_d, w_d, b_d, cin_d, cnt_d, so_d} = {st_q, op_q, w_q, b_q, cin_q, cnt_q, so_q};
    {res_d, c_d, v_d, z_d, n_d} = {res_q, c_q, v_q, z_q, n_q};
    if (st_q == S_IDLE && start) begin
      {st_d, op_d, w_d, b_d, cin_d, so_d} = {S_EXEC, op, a, b, carryin, 1'b0};
      cnt_d = op inside {4'd8, 4'd9, 4'd10} ? CW'(b[SHW-1:0]) : (MUL_EN && op == 4'd12) ? CW'(WIDTH) : '0;
    end else if (st_q == S_EXEC && fin) begin
      st_d = S_DONE;
      res_d = upd_res ? r : res_q;
      {c_d, v_d, z_d, n_d} = upd_flg ? {c, v, ~|r, r[WIDTH-1]} : {c_q, v_q, z_q, n_q};
    end else if (st_q == S_EXEC) begin
      w_d = is_sh ? sh_val : w_q;
      so_d = sh_v;
      cnt_d = cnt_q - CW'(1);
    end else if (st_q == S_DONE) st_d = S_IDLE;
  end
  // state registers, cleared asynchronously so an in-flight op is aborted without commit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {st_q, op_q, w_q, b_q, cin_q, cnt_q, so_q} <= '0;
      {res_q, c_q, v_q, z_q, n_q} <= '0;
    end else begin
      {st_q, op_q, w_q, b_q, cin_q, cnt_q, so_q} <= {st_d, op_d, w_d, b_d, cin_d, cnt_d, so_d};
      {res_q, c_q, v_q, z_q, n_q} <= {res_d, c_d, v_d, z_d, n_d};
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand sequences for start-ignore, oe gating and mid-op reset
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, carryin = 1'b0, oe = 1'b1;
  logic [3:0] op = '0;
  logic [7:0] a = '0, b = '0, aluout;
  logic carryout, overout, zeroout, negout, busy, done;
  int tests = 0, fails = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    logic cin;
    int lat;
    logic [7:0] res;
    logic c, v, z, n;
  } vec_t;
  vec_t tv [19];

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .carryin(carryin), .oe(oe),
    .aluout(aluout), .carryout(carryout), .overout(overout), .zeroout(zeroout), .negout(negout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t t, output int cyc);
    @(negedge clk);
    {op, a, b, carryin, start} = {t.op, t.a, t.b, t.cin, 1'b1};
    @(negedge clk);
    {op, a, b, carryin, start} = {~t.op, ~t.a, ~t.b, ~t.cin, 1'b0};
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, dn;
    tv[0]  = '{4'd0,  8'h7F, 8'h01, 1'b0, 2, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[1]  = '{4'd2,  8'h10, 8'h20, 1'b0, 2, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{4'd11, 8'h55, 8'h55, 1'b0, 2, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{4'd1,  8'hFF, 8'h00, 1'b1, 2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[4]  = '{4'd3,  8'h05, 8'h03, 1'b0, 2, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{4'd4,  8'hF0, 8'h3C, 1'b0, 2, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{4'd5,  8'h0F, 8'h30, 1'b0, 2, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{4'd6,  8'hFF, 8'h0F, 1'b0, 2, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[8]  = '{4'd7,  8'h55, 8'h00, 1'b0, 2, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{4'd8,  8'h81, 8'h03, 1'b0, 4, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[10] = '{4'd9,  8'hA5, 8'h00, 1'b0, 2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[11] = '{4'd9,  8'h81, 8'h01, 1'b0, 2, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[12] = '{4'd10, 8'h80, 8'h07, 1'b0, 8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[13] = '{4'd2,  8'h80, 8'h01, 1'b0, 2, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[14] = '{4'd13, 8'h00, 8'h00, 1'b0, 2, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef ALU_SEQ_MUL_EN
    tv[15] = '{4'd12, 8'h10, 8'h11, 1'b0, 9, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    tv[15] = '{4'd12, 8'h10, 8'h11, 1'b0, 2, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    tv[16] = '{4'd8,  8'h40, 8'h01, 1'b0, 2, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[17] = '{4'd8,  8'h01, 8'h08, 1'b0, 2, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[18] = '{4'd2,  8'h00, 8'h00, 1'b0, 2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset busy/done", {busy, done}, 0);
    chk("reset out/flags", {aluout, carryout, overout, zeroout, negout}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      run(tv[i], cyc);
      chk($sformatf("v%0d latency", i), cyc, tv[i].lat);
      chk($sformatf("v%0d aluout", i), aluout, tv[i].res);
      chk($sformatf("v%0d c/v/z/n", i), {carryout, overout, zeroout, negout}, {tv[i].c, tv[i].v, tv[i].z, tv[i].n});
    end
    @(negedge clk);
    chk("idle after done", {busy, done}, 0);
    {op, a, b, start} = {4'd8, 8'h01, 8'h03, 1'b1};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    {op, a, b, start} = {4'd0, 8'h01, 8'h01, 1'b1};
    @(negedge clk);
    start = 1'b0;
    chk("busy mid-shift", busy, 1);
    @(negedge clk);
    chk("shift done at +4", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start in DONE ignored", busy, 0);
    chk("shift result kept", aluout, 8'h08);
    oe = 1'b0;
    #1 chk("oe=0 zero", aluout, 0);
    oe = 1'b1;
    #1 chk("oe=1 retained", aluout, 8'h08);
    @(negedge clk);
    {op, a, b, start} = {4'd9, 8'hFF, 8'h07, 1'b1};
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset mid-op busy/done", {busy, done}, 0);
    chk("reset mid-op out", {aluout, carryout, overout, zeroout, negout}, 0);
    {op, a, b, start} = {4'd0, 8'h01, 8'h01, 1'b1};
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dn += int'(done || busy);
    end
    chk("no activity after reset", dn, 0);
    chk("result still zero", aluout, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
